// File: rtl/regfile_writeback.sv
// Write-side front end for the 32x32 register file: merges ALU results and buffered load returns
// onto a single registered write port. Optional load bypass when built with WB_BYPASS_EN defined.
module regfile_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_valid,
    input  logic [ADDR_WIDTH-1:0]         alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    output logic                          alu_ready,
    input  logic                          mem_valid,
    input  logic [ADDR_WIDTH-1:0]         mem_rd,
    input  logic [DATA_WIDTH-1:0]         mem_data,
    output logic                          mem_ready,
    output logic                          wr_en,
    output logic [ADDR_WIDTH-1:0]         rd,
    output logic [DATA_WIDTH-1:0]         data_wr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [31:0]                   busy_mask
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] rd_mem   [FIFO_DEPTH];

    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic                  full, empty;
    logic                  alu_fire, mem_fire;
    logic                  bypass, push, pop;
    logic                  sel_valid;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;

    // Readiness depends only on the registered occupancy, never on the incoming valids.
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign alu_ready = !full;
    assign mem_ready = !full;
    assign alu_fire  = alu_valid && !full;
    assign mem_fire  = mem_valid && !full;

`ifdef WB_BYPASS_EN
    assign bypass = mem_fire && !alu_valid && empty && (mem_rd != '0);
`else
    assign bypass = 1'b0;
`endif

    // x0 loads complete the handshake but are never stored.
    assign push = mem_fire && (mem_rd != '0) && !bypass;
    assign pop  = !alu_fire && !empty;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (alu_fire) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
        end else if (bypass) begin
            sel_valid = 1'b1;
            sel_rd    = mem_rd;
            sel_data  = mem_data;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = rd_mem[rptr_q];
            sel_data  = data_mem[rptr_q];
        end
    end

    always_comb begin
        wr_en_d = sel_valid && (sel_rd != '0);
        rd_d    = wr_en_d ? sel_rd   : rd_q;
        data_d  = wr_en_d ? sel_data : data_q;
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            wr_en_q <= 1'b0;
            rd_q    <= '0;
            data_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            wr_en_q <= wr_en_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
        end
    end

    // NOTE: the storage array is not reset; entries are only meaningful between rptr and wptr.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wptr_q] <= mem_data;
            rd_mem[wptr_q]   <= mem_rd;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            logic [PTR_W-1:0] offs;
            offs = PTR_W'(i) - rptr_q;
            if ({1'b0, offs} < count_q) begin
                busy_mask = busy_mask | (32'd1 << rd_mem[i]);
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign rd         = rd_q;
    assign data_wr    = data_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Randomized scoreboard bench for regfile_writeback; a queue-based model predicts every write.
module tb_regfile_writeback;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid;
    logic [AW-1:0] alu_rd, mem_rd;
    logic [DW-1:0] alu_data, mem_data;
    logic          alu_ready, mem_ready;
    logic          wr_en;
    logic [AW-1:0] rd;
    logic [DW-1:0] data_wr;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [31:0]   busy_mask;

    always #5 clk = ~clk;

    regfile_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .wr_en(wr_en), .rd(rd), .data_wr(data_wr),
        .fifo_count(fifo_count), .busy_mask(busy_mask)
    );

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
    } ld_t;

    typedef struct {
        logic [AW-1:0] rd;
        logic [DW-1:0] data;
        int            due;
    } wb_t;

    ld_t model_q[$];
    wb_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;
    bit  mon_on = 1'b0;
    bit  after_rst = 1'b1;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        foreach (model_q[i]) m |= 32'd1 << model_q[i].rd;
        return m;
    endfunction

    function automatic logic [AW-1:0] rnd_rd();
        return ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
    endfunction

    // One clock of stimulus: check visible state, drive inputs, predict the coming edge.
    task automatic step(input logic r, input logic av, input logic [AW-1:0] ard,
                        input logic [DW-1:0] ad, input logic mv, input logic [AW-1:0] mrd,
                        input logic [DW-1:0] md);
        bit  full;
        bit  byp;
        ld_t h;
        @(negedge clk);
        mon_on = 1'b1;
        full = (model_q.size() == DEPTH);
        check("fifo_count", 64'(fifo_count), 64'(model_q.size()));
        check("busy_mask", 64'(busy_mask), 64'(model_mask()));
        check("alu_ready", 64'(alu_ready), 64'(!full));
        check("mem_ready", 64'(mem_ready), 64'(!full));
        if (after_rst) begin
            check("reset_rd", 64'(rd), 64'd0);
            check("reset_data_wr", 64'(data_wr), 64'd0);
        end
        rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
        if (r) begin
            model_q.delete();
            after_rst = 1'b1;
        end else begin
            after_rst = 1'b0;
            byp = 1'b0;
`ifdef WB_BYPASS_EN
            byp = !av && mv && (mrd != 0) && (model_q.size() == 0);
`endif
            if (av && !full) begin
                if (ard != 0) exp_q.push_back('{ard, ad, cyc + 1});
            end else if (byp) begin
                exp_q.push_back('{mrd, md, cyc + 1});
            end else if (model_q.size() > 0) begin
                h = model_q.pop_front();
                exp_q.push_back('{h.rd, h.data, cyc + 1});
            end
            if (mv && !full && (mrd != 0) && !byp) model_q.push_back('{mrd, md});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    // Monitor: each cycle either exactly the predicted write appears or the port stays idle.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    e = exp_q.pop_front();
                    check("wr_en", 64'(wr_en), 64'd1);
                    check("wr_rd", 64'(rd), 64'(e.rd));
                    check("wr_data", 64'(data_wr), 64'(e.data));
                end else begin
                    check("wr_en_idle", 64'(wr_en), 64'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; alu_valid = 1'b0; mem_valid = 1'b0;
        alu_rd = '0; mem_rd = '0; alu_data = '0; mem_data = '0;
        repeat (2) @(posedge clk);

        // single ALU write, then a single load
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        idle(2);
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 32'h12345678);
        idle(3);

        // fill the FIFO under continuous ALU traffic, then let everything retire
        for (int i = 1; i <= 4; i++)
            step(1'b0, 1'b1, 5'd20 + 5'(i), 32'hA000_0000 + i, 1'b1, 5'(i), 32'hB000_0000 + i);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 5'd9, 32'hC000_0000 + i, 1'b0, '0, '0);
        idle(6);

        // x0 from both sources
        step(1'b0, 1'b1, 5'd0, 32'h1111_1111, 1'b1, 5'd0, 32'h2222_2222);
        idle(3);

        // steady push/pop at occupancy 2 across pointer wrap
        step(1'b0, 1'b1, 5'd3, 32'h3333_0000, 1'b1, 5'd13, 32'hD000_0001);
        step(1'b0, 1'b1, 5'd3, 32'h3333_0001, 1'b1, 5'd14, 32'hD000_0002);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 5'd15 + 5'(i), 32'hE000_0000 + i);
        idle(4);

        // reset with three queued loads and a write on the port
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, 5'd25, 32'hF000_0000 + i, 1'b1, 5'd10 + 5'(i), 32'h5000_0000 + i);
        step(1'b1, 1'b1, 5'd26, 32'h6666_6666, 1'b1, 5'd27, 32'h7777_7777);
        idle(6);

        // random traffic with occasional resets
        for (int k = 0; k < 800; k++)
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), rnd_rd(), $urandom(),
                 ($urandom_range(0, 9) < 6), rnd_rd(), $urandom());
        idle(12);

        @(negedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
